// File: rtl/sp_dma_pkg.sv
// Shared SRAM geometry for the SP core, its controller, the SRAM and the DMA engine.
package sp_dma_pkg;

    localparam int SP_ADDR_W = 16;
    localparam int SP_DATA_W = 32;
    localparam int SP_LEN_W  = 16;

endpackage

// File: rtl/sp_dma.sv
// Block-copy engine sharing the SP SRAM port; moves len words from src to dst,
// touching the port only in cycles where grant is high.
//
// state | meaning
// IDLE  | waiting for start; parameters latched on accept
// RD    | issue read of src+i when granted
// WT    | capture read data into buf
// WR    | issue write of buf to dst+i when granted
// DN    | one-cycle done pulse

module sp_dma
    import sp_dma_pkg::*;
#(
    parameter int ADDR_W = SP_ADDR_W,
    parameter int DATA_W = SP_DATA_W,
    parameter int LEN_W  = SP_LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [LEN_W-1:0]  len,
    input  logic              grant,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_di,
    output logic              mem_en,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_do,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WT   = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DN   = 3'd4;

    logic [2:0]        state;
    logic [LEN_W-1:0]  idx;
    logic [ADDR_W-1:0] src_r;
    logic [ADDR_W-1:0] dst_r;
    logic [LEN_W-1:0]  len_r;
    logic [DATA_W-1:0] buf_r;
    logic              last_word;

    // len_r is nonzero whenever WR is reachable, so len_r-1 never underflows there
    assign last_word = (idx == len_r - LEN_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            idx   <= '0;
            src_r <= '0;
            dst_r <= '0;
            len_r <= '0;
            buf_r <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        src_r <= src;
                        dst_r <= dst;
                        len_r <= len;
                        idx   <= '0;
                        state <= (len == '0) ? S_DN : S_RD;
                    end
                end
                S_RD: begin
                    if (grant) state <= S_WT;
                end
                S_WT: begin
                    buf_r <= mem_do;
                    state <= S_WR;
                end
                S_WR: begin
                    if (grant) begin
                        if (last_word) begin
                            state <= S_DN;
                        end else begin
                            idx   <= idx + LEN_W'(1);
                            state <= S_RD;
                        end
                    end
                end
                S_DN:    state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Port drive is purely combinational so the SP-top mux sees it in the granted cycle
    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_di   = '0;
        if (grant) begin
            if (state == S_RD) begin
                mem_en   = 1'b1;
                mem_addr = src_r + ADDR_W'(idx);
            end else if (state == S_WR) begin
                mem_en   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = dst_r + ADDR_W'(idx);
                mem_di   = buf_r;
            end
        end
    end

    assign busy = (state == S_RD) || (state == S_WT) || (state == S_WR);
    assign done = (state == S_DN);

endmodule

// File: tb/tb_sp_dma.sv
// Bench for sp_dma: SRAM model plus a word-level forward-copy reference.
module tb_sp_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
    logic        grant;
    logic [15:0] mem_addr;
    logic [31:0] mem_di;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_do;
    logic        busy;
    logic        done;

    logic [31:0] mem     [0:65535];
    logic [31:0] ref_mem [0:65535];
    logic        pl_en;
    logic [15:0] pl_addr;
    logic [31:0] pl_data;

    int checks   = 0;
    int failures = 0;
    int en_cycles = 0;

    sp_dma dut (
        .clk(clk), .reset(reset), .start(start), .src(src), .dst(dst), .len(len),
        .grant(grant), .mem_addr(mem_addr), .mem_di(mem_di), .mem_en(mem_en),
        .mem_we(mem_we), .mem_do(mem_do), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // SRAM: synchronous, read data valid the cycle after the access
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_di;
            else        mem_do <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_en === 1'b1) en_cycles++;
        if (reset === 1'b0 && grant === 1'b0) chk("en_without_grant", {63'd0, mem_en}, 64'd0);
    end

    task automatic preload(input logic [15:0] a, input logic [31:0] v);
        pl_en = 1'b1; pl_addr = a; pl_data = v;
        ref_mem[a] = v;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic prep(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
        for (int k = -1; k <= int'(l); k++) preload(d + 16'(k), $urandom);
        for (int k = 0; k < int'(l); k++) preload(s + 16'(k), $urandom);
    endtask

    // mode 0: grant always 1; 1: grant low for cycles after edges 2..6;
    // 2: random grant; 3: grant 1 with a stray start mid-transfer
    task automatic xfer(input string tag, input logic [15:0] s, input logic [15:0] d,
                        input logic [15:0] l, input int mode, input int exp_edge);
        int edge_n = 0;
        int done_edge = -1;
        int busy_cnt = 0;
        int en0;
        src = s; dst = d; len = l; start = 1'b1; grant = 1'b1;
        en0 = en_cycles;
        @(posedge clk); #1;
        start = 1'b0;
        while (done_edge < 0 && edge_n < 400) begin
            if (done === 1'b1) done_edge = edge_n;
            else if (busy === 1'b1) busy_cnt++;
            case (mode)
                1:       grant = !(edge_n >= 2 && edge_n <= 6);
                2:       grant = ($urandom_range(0, 3) != 0);
                default: grant = 1'b1;
            endcase
            if (mode == 3 && edge_n == 1) begin
                start = 1'b1; src = s + 16'h55; dst = s; len = l + 16'd3;
            end else begin
                start = 1'b0;
            end
            if (done_edge < 0) begin
                @(posedge clk); #1;
                edge_n++;
            end
        end
        grant = 1'b1;
        chk({tag, "_done_seen"}, {63'd0, done_edge >= 0}, 64'd1);
        if (exp_edge >= 0) chk({tag, "_done_edge"}, 64'(done_edge), 64'(exp_edge));
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(done_edge));
        if (l == 16'd0) chk({tag, "_no_mem_en"}, 64'(en_cycles - en0), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_done_pulse_1"}, {62'd0, done, busy}, 64'd0);
        for (int k = 0; k < int'(l); k++) ref_mem[d + 16'(k)] = ref_mem[s + 16'(k)];
        for (int k = -1; k <= int'(l); k++)
            chk($sformatf("%s_data[%0d]", tag, k), {32'd0, mem[d + 16'(k)]}, {32'd0, ref_mem[d + 16'(k)]});
    endtask

    initial begin
        logic [15:0] rs, rd, rl;
        int saw_done;
        reset = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0; grant = 1'b0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {mem_addr, mem_di, mem_en, mem_we, busy, done}, 64'd0);
        reset = 1'b0;
        grant = 1'b1;

        prep(16'h0100, 16'h0200, 16'd4);
        xfer("basic", 16'h0100, 16'h0200, 16'd4, 0, 12);

        prep(16'h0500, 16'h0600, 16'd0);
        xfer("zero_len", 16'h0500, 16'h0600, 16'd0, 0, 0);

        prep(16'h0700, 16'h0800, 16'd2);
        xfer("stall", 16'h0700, 16'h0800, 16'd2, 1, 11);

        prep(16'hFFFE, 16'h0010, 16'd4);
        xfer("wrap", 16'hFFFE, 16'h0010, 16'd4, 0, 12);

        prep(16'h0040, 16'h0041, 16'd3);
        xfer("overlap", 16'h0040, 16'h0041, 16'd3, 0, 9);

        prep(16'h0900, 16'h0A00, 16'd3);
        xfer("mid_start", 16'h0900, 16'h0A00, 16'd3, 3, 9);

        for (int t = 0; t < 6; t++) begin
            rs = 16'($urandom); rd = 16'($urandom); rl = 16'($urandom_range(1, 8));
            prep(rs, rd, rl);
            xfer($sformatf("rand%0d", t), rs, rd, rl, 2, -1);
        end

        // Abort during the second word's WT: first word lands, nothing else does
        prep(16'h0300, 16'h0380, 16'd3);
        src = 16'h0300; dst = 16'h0380; len = 16'd3; start = 1'b1; grant = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        chk("abort_busy_before", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        #1;
        chk("abort_outputs", {mem_addr, mem_di, mem_en, mem_we, busy, done}, 64'd0);
        saw_done = 0;
        repeat (2) begin @(posedge clk); #1; if (done === 1'b1) saw_done = 1; end
        reset = 1'b0;
        repeat (4) begin @(posedge clk); #1; if (done === 1'b1) saw_done = 1; end
        chk("abort_no_done", 64'(saw_done), 64'd0);
        chk("abort_word0", {32'd0, mem[16'h0380]}, {32'd0, ref_mem[16'h0300]});
        chk("abort_word1", {32'd0, mem[16'h0381]}, {32'd0, ref_mem[16'h0381]});
        ref_mem[16'h0380] = ref_mem[16'h0300];

        prep(16'h0B00, 16'h0C00, 16'd4);
        xfer("restart", 16'h0B00, 16'h0C00, 16'd4, 0, 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
